axil_cmd_master: RTL and testbench

//  Command-driven AXI4-Lite master. Takes one register read or write per command from local logic
//  (a sequencer, or a PCIe/UART bridge) and issues it on an AXI4-Lite bus. Returns the read data
//  and response code. Sits directly upstream of AXI4-Lite register slaves such as axil_slave.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_cmd_master.sv | 177 +++++++++++++++++
 tb/tb_axil_cmd_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command-master state encoding.
package axil_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'd0;
   localparam logic [1:0] AXI_EXOKAY = 2'd1;
   localparam logic [1:0] AXI_SLVERR = 2'd2;
   localparam logic [1:0] AXI_DECERR = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RDATA,
      S_RESPOND
   } axil_state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// Command-driven AXI4-Lite master: one register read/write per command, one outstanding,
// with an optional watchdog that abandons a stuck transaction and reports SLVERR.
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int unsigned AW      = 8,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic          clk,
   input  logic          resetn,

   input  logic [AW-1:0] CMD_ADDR,
   input  logic [31:0]   CMD_WDATA,
   input  logic [3:0]    CMD_WSTRB,
   input  logic          CMD_WRITE,
   input  logic          CMD_VALID,
   output logic          CMD_READY,

   output logic [31:0]   RSP_RDATA,
   output logic [1:0]    RSP_RESP,
   output logic          RSP_TIMEOUT,
   output logic          RSP_VALID,
   input  logic          RSP_READY,

   output logic [AW-1:0] M_AXI_AWADDR,
   output logic [2:0]    M_AXI_AWPROT,
   output logic          M_AXI_AWVALID,
   input  logic          M_AXI_AWREADY,
   output logic [31:0]   M_AXI_WDATA,
   output logic [3:0]    M_AXI_WSTRB,
   output logic          M_AXI_WVALID,
   input  logic          M_AXI_WREADY,
   input  logic [1:0]    M_AXI_BRESP,
   input  logic          M_AXI_BVALID,
   output logic          M_AXI_BREADY,
   output logic [AW-1:0] M_AXI_ARADDR,
   output logic [2:0]    M_AXI_ARPROT,
   output logic          M_AXI_ARVALID,
   input  logic          M_AXI_ARREADY,
   input  logic [31:0]   M_AXI_RDATA,
   input  logic [1:0]    M_AXI_RRESP,
   input  logic          M_AXI_RVALID,
   output logic          M_AXI_RREADY
);

   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   axil_state_e   state;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [CW-1:0] wd_cnt;

   logic busy, wd_hit, completing, abort;
   logic aw_done, w_done;

   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = wstrb_q;
   assign M_AXI_AWPROT = '0;
   assign M_AXI_ARPROT = '0;

   always_comb begin
      busy       = (state == S_WRITE) || (state == S_WRESP) ||
                   (state == S_READ)  || (state == S_RDATA);
      wd_hit     = (TIMEOUT != 0) && (wd_cnt == TMAX - 1'b1);
      // A response arriving in the watchdog's final cycle still wins over the abort.
      completing = ((state == S_WRESP) && M_AXI_BVALID) ||
                   ((state == S_RDATA) && M_AXI_RVALID);
      abort      = busy && wd_hit && !completing;
      aw_done    = !M_AXI_AWVALID || M_AXI_AWREADY;
      w_done     = !M_AXI_WVALID  || M_AXI_WREADY;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         CMD_READY     <= 1'b0;
         RSP_RDATA     <= '0;
         RSP_RESP      <= '0;
         RSP_TIMEOUT   <= 1'b0;
         RSP_VALID     <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         wd_cnt        <= '0;
      end else begin
         if (busy && (wd_cnt != TMAX))
            wd_cnt <= wd_cnt + 1'b1;

         if (abort) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            RSP_RDATA     <= '0;
            RSP_RESP      <= AXI_SLVERR;
            RSP_TIMEOUT   <= 1'b1;
            RSP_VALID     <= 1'b1;
            state         <= S_RESPOND;
         end else begin
            case (state)
               S_IDLE: begin
                  CMD_READY <= 1'b1;
                  if (CMD_VALID && CMD_READY) begin
                     CMD_READY <= 1'b0;
                     addr_q    <= CMD_ADDR;
                     wdata_q   <= CMD_WDATA;
                     wstrb_q   <= CMD_WSTRB;
                     wd_cnt    <= '0;
                     if (CMD_WRITE) begin
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= S_WRITE;
                     end else begin
                        M_AXI_ARVALID <= 1'b1;
                        state         <= S_READ;
                     end
                  end
               end
               S_WRITE: begin
                  if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                  if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                  if (aw_done && w_done) begin
                     M_AXI_BREADY <= 1'b1;
                     state        <= S_WRESP;
                  end
               end
               S_WRESP: begin
                  if (M_AXI_BVALID) begin
                     M_AXI_BREADY <= 1'b0;
                     RSP_RDATA    <= '0;
                     RSP_RESP     <= M_AXI_BRESP;
                     RSP_TIMEOUT  <= 1'b0;
                     RSP_VALID    <= 1'b1;
                     state        <= S_RESPOND;
                  end
               end
               S_READ: begin
                  if (M_AXI_ARREADY) begin
                     M_AXI_ARVALID <= 1'b0;
                     M_AXI_RREADY  <= 1'b1;
                     state         <= S_RDATA;
                  end
               end
               S_RDATA: begin
                  if (M_AXI_RVALID) begin
                     M_AXI_RREADY <= 1'b0;
                     RSP_RDATA    <= M_AXI_RDATA;
                     RSP_RESP     <= M_AXI_RRESP;
                     RSP_TIMEOUT  <= 1'b0;
                     RSP_VALID    <= 1'b1;
                     state        <= S_RESPOND;
                  end
               end
               S_RESPOND: begin
                  if (RSP_READY) begin
                     RSP_VALID <= 1'b0;
                     CMD_READY <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master against a stall-able register-slave stub
// (0x00/0x04 read-write, 0x08 read-only sum of the two, anything else DECERR).
module tb_axil_cmd_master;
   import axil_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        cmd_write = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout, rsp_valid;
   logic        rsp_ready = 1'b1;

   logic [7:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axil_cmd_master #(.AW(8), .TIMEOUT(16)) dut (
      .clk(clk), .resetn(resetn),
      .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
      .CMD_WRITE(cmd_write), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp), .RSP_TIMEOUT(rsp_timeout),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
      .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
      .M_AXI_RREADY(rready)
   );

   // Stub slave: *_len = total cycles VALID stays high before READY completes it.
   int          aw_len = 1, w_len = 1;
   bit          b_never = 1'b0, r_never = 1'b0;
   int          aw_n = 0, w_n = 0;
   logic        aw_got = 1'b0, w_got = 1'b0;
   logic [7:0]  aw_a = '0;
   logic [31:0] w_d = '0;
   logic [3:0]  w_s = '0;
   logic [31:0] reg0 = '0, reg1 = '0;
   logic        s_aw_now, s_w_now;
   logic [7:0]  s_addr;
   logic [31:0] s_data;
   logic [3:0]  s_strb;

   assign awready = awvalid && !aw_got && (aw_n >= aw_len - 1);
   assign wready  = wvalid  && !w_got  && (w_n  >= w_len  - 1);
   assign arready = arvalid;

   always @(posedge clk) begin
      if (!resetn) begin
         aw_got <= 1'b0; w_got <= 1'b0; aw_n <= 0; w_n <= 0;
         bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      end else begin
         if (awvalid && !aw_got) aw_n <= awready ? 0 : aw_n + 1;
         if (wvalid && !w_got)   w_n  <= wready  ? 0 : w_n + 1;
         s_aw_now = aw_got || (awvalid && awready);
         s_w_now  = w_got  || (wvalid && wready);
         s_addr   = aw_got ? aw_a : awaddr;
         s_data   = w_got ? w_d : wdata;
         s_strb   = w_got ? w_s : wstrb;
         if (bvalid && bready) bvalid <= 1'b0;
         if (s_aw_now && s_w_now) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= !b_never;
            bresp  <= AXI_OKAY;
            for (int i = 0; i < 4; i++) begin
               if (s_strb[i] && s_addr == 8'h00) reg0[8*i +: 8] <= s_data[8*i +: 8];
               if (s_strb[i] && s_addr == 8'h04) reg1[8*i +: 8] <= s_data[8*i +: 8];
            end
            if (s_addr != 8'h00 && s_addr != 8'h04) bresp <= AXI_DECERR;
         end else begin
            if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= !r_never;
            rresp  <= AXI_OKAY;
            case (araddr)
               8'h00:   rdata <= reg0;
               8'h04:   rdata <= reg1;
               8'h08:   rdata <= reg0 + reg1;
               default: begin rdata <= '0; rresp <= AXI_DECERR; end
            endcase
         end
      end
   end

   int cyc = 0, aw_hi = 0, w_hi = 0, b_hs = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid)  w_hi  <= w_hi + 1;
      if (bvalid && bready) b_hs <= b_hs + 1;
   end

   typedef struct { logic [31:0] rdata; logic [1:0] resp; logic to; } exp_t;
   exp_t exp_q[$];
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares each response in the cycle it is handshaken.
   always @(negedge clk) begin
      if (resetn && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rdata 0x%0h resp %0d, expected none", rsp_rdata, rsp_resp);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
         end
      end
   end

   int acc_cyc = 0;

   // Called at posedge+1; accept happens at the end of cycle acc_cyc.
   task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input bit has_rsp, input logic [31:0] er, input logic [1:0] ep, input bit et);
      int n = 0;
      if (has_rsp) exp_q.push_back('{er, ep, et});
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL cmd_accept: got no CMD_READY in 200 cycles, expected accept");
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      int n = 0;
      while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
      if (!rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_wait: got no RSP_VALID in 200 cycles, expected response");
      end
      lat = cyc - acc_cyc;
   endtask

   initial begin
      int lat, a0, w0, b0, hs;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 0);
      chk("rst_axi_vr", {awvalid, wvalid, bready, arvalid, rready, rsp_timeout}, 0);
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("idle_cmd_ready", 32'(cmd_ready), 1);

      // 1: basic writes and summed read, zero-wait slave
      issue(1, 8'h00, 32'd5, 1, 0, AXI_OKAY, 0);
      wait_rsp(lat); chk("write_latency", lat, 3);
      @(posedge clk); #1;
      issue(1, 8'h04, 32'd7, 1, 0, AXI_OKAY, 0);
      wait_rsp(lat); @(posedge clk); #1;
      issue(0, 8'h08, 32'hDEAD_BEEF, 1, 32'd12, AXI_OKAY, 0);
      wait_rsp(lat); chk("read_latency", lat, 3);
      @(posedge clk); #1;

      // 2: decode errors
      issue(1, 8'h0C, 32'h1234_5678, 1, 0, AXI_DECERR, 0);
      wait_rsp(lat); @(posedge clk); #1;
      issue(0, 8'h10, 32'h0, 1, 0, AXI_DECERR, 0);
      wait_rsp(lat); @(posedge clk); #1;

      // 3: AW and W completing in either order
      aw_len = 4; w_len = 1;
      a0 = aw_hi; w0 = w_hi; b0 = b_hs;
      issue(1, 8'h00, 32'd5, 1, 0, AXI_OKAY, 0);
      wait_rsp(lat); @(posedge clk); #1;
      chk("awvalid_cycles_aw4", aw_hi - a0, 4);
      chk("wvalid_cycles_w1", w_hi - w0, 1);
      chk("b_handshakes_a", b_hs - b0, 1);
      aw_len = 1; w_len = 4;
      a0 = aw_hi; w0 = w_hi; b0 = b_hs;
      issue(1, 8'h00, 32'd5, 1, 0, AXI_OKAY, 0);
      wait_rsp(lat); @(posedge clk); #1;
      chk("awvalid_cycles_aw1", aw_hi - a0, 1);
      chk("wvalid_cycles_w4", w_hi - w0, 4);
      chk("b_handshakes_b", b_hs - b0, 1);
      w_len = 1;

      // 4: response back-pressure, then back-to-back accept
      rsp_ready = 1'b0;
      issue(0, 8'h08, 32'h0, 1, 32'd12, AXI_OKAY, 0);
      wait_rsp(lat);
      for (int i = 0; i < 10; i++) begin
         chk("hold_rsp_valid", 32'(rsp_valid), 1);
         chk("hold_rsp_rdata", rsp_rdata, 32'd12);
         chk("hold_cmd_ready", 32'(cmd_ready), 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      hs = cyc;
      issue(1, 8'h04, 32'd7, 1, 0, AXI_OKAY, 0);
      chk("b2b_accept_cycle", acc_cyc - hs, 1);
      wait_rsp(lat); @(posedge clk); #1;

      // 5: watchdog expiry with BVALID never arriving
      b_never = 1'b1;
      issue(1, 8'h00, 32'd5, 1, 0, AXI_SLVERR, 1);
      wait_rsp(lat);
      chk("timeout_latency", lat, 17);
      chk("timeout_bready", 32'(bready), 0);
      @(posedge clk); #1;
      repeat (3) begin
         chk("late_bready", 32'(bready), 0);
         @(posedge clk); #1;
      end
      b_never = 1'b0;

      // 6: reset while waiting in RDATA
      r_never = 1'b1;
      issue(0, 8'h00, 32'h0, 0, 0, AXI_OKAY, 0);
      @(posedge clk); #1;
      chk("rdata_rready", 32'(rready), 1);
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("midrst_axi_vr", {awvalid, wvalid, bready, arvalid, rready}, 0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 0);
      resetn = 1'b1;
      r_never = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
      issue(0, 8'h04, 32'h0, 1, 32'd7, AXI_OKAY, 0);
      wait_rsp(lat); @(posedge clk); #1;

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no completion by 200us, expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
